// File: rtl/hash_dictionary_engine_if.sv
// hash_dictionary_engine_if
//   Request/response bundle for the hash dictionary engine.
//   Request side : req_valid/req_ready handshake carrying req_op, req_key, req_data.
//   Response side: rsp_valid/rsp_ready handshake carrying rsp_hit, rsp_full, rsp_data.
//   entry_count  : live number of valid entries in the table.
//   master modport = requester, slave modport = engine.
interface hash_dictionary_engine_if #(
  parameter int KEY_W  = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 7
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [KEY_W-1:0]  req_key;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_hit;
  logic              rsp_full;
  logic [DATA_W-1:0] rsp_data;
  logic [CNT_W-1:0]  entry_count;

  modport master (
    output req_valid, req_op, req_key, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_hit, rsp_full, rsp_data, entry_count
  );

  modport slave (
    input  req_valid, req_op, req_key, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_hit, rsp_full, rsp_data, entry_count
  );
endinterface

// File: rtl/hash_dictionary_engine.sv
// hash_dictionary_engine
//   Bucketed, set-associative key/data dictionary with a probing state machine.
//   Operations: lookup (00), insert/update (01), delete (10), clear (11).
//   Ports:
//     i_clk  - clock, all state changes on the rising edge
//     i_rst  - asynchronous active-high reset; empties the table, drops any in-flight op
//     bus    - slave side of hash_dictionary_engine_if (request, response, entry_count)
module hash_dictionary_engine #(
  parameter int KEY_W   = 8,
  parameter int DATA_W  = 8,
  parameter int BUCKETS = 16,
  parameter int WAYS    = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  hash_dictionary_engine_if.slave  bus
);
  localparam int IDX_W   = $clog2(BUCKETS);
  localparam int ENTRIES = BUCKETS * WAYS;
  localparam int ADDR_W  = $clog2(ENTRIES);
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CNT_W   = $clog2(ENTRIES + 1);
  localparam int NCHUNK  = (KEY_W + IDX_W - 1) / IDX_W;
  localparam int PAD_W   = NCHUNK * IDX_W;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_RESP, S_CLEAR} state_t;

  state_t             r_state, w_state_next;
  logic [1:0]         r_op;
  logic [KEY_W-1:0]   r_key;
  logic [DATA_W-1:0]  r_data;
  logic [IDX_W-1:0]   r_bucket;
  logic [WAY_W-1:0]   r_way;
  logic               r_free_found;
  logic [WAY_W-1:0]   r_free_way;
  logic [IDX_W:0]     r_clr_idx;
  logic [CNT_W-1:0]   r_count;
  logic               r_rsp_hit, r_rsp_full;
  logic [DATA_W-1:0]  r_rsp_data;
  logic [ENTRIES-1:0] r_valid;
  logic [KEY_W-1:0]   r_mem_key  [ENTRIES];
  logic [DATA_W-1:0]  r_mem_data [ENTRIES];

  // Bucket index: key zero-padded to whole IDX_W chunks, chunks XOR-folded.
  logic [PAD_W-1:0] w_key_pad;
  logic [IDX_W-1:0] w_hash;
  always_comb begin
    w_key_pad = PAD_W'(bus.req_key);
    w_hash    = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      w_hash = w_hash ^ w_key_pad[i*IDX_W +: IDX_W];
    end
  end

  logic [ADDR_W-1:0] w_addr, w_free_addr;
  logic              w_match, w_last;
  assign w_addr      = ADDR_W'(r_bucket) * ADDR_W'(WAYS) + ADDR_W'(r_way);
  assign w_free_addr = ADDR_W'(r_bucket) * ADDR_W'(WAYS) + ADDR_W'(r_free_way);
  // Occupancy comes only from the valid bit, so key 0 is an ordinary key.
  assign w_match     = r_valid[w_addr] && (r_mem_key[w_addr] == r_key);
  assign w_last      = (r_way == WAY_W'(WAYS - 1));

  logic              w_accept, w_finish, w_hit_n, w_full_n;
  logic [DATA_W-1:0] w_data_n;
  logic              w_wr_en, w_set_valid, w_clr_valid, w_inc, w_dec, w_clr_bucket, w_clr_cnt;
  logic [ADDR_W-1:0] w_wr_addr;

  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    w_finish      = 1'b0;
    w_hit_n       = 1'b0;
    w_full_n      = 1'b0;
    w_data_n      = '0;
    w_wr_en       = 1'b0;
    w_wr_addr     = w_addr;
    w_set_valid   = 1'b0;
    w_clr_valid   = 1'b0;
    w_inc         = 1'b0;
    w_dec         = 1'b0;
    w_clr_bucket  = 1'b0;
    w_clr_cnt     = 1'b0;
    bus.req_ready = (r_state == S_IDLE);
    bus.rsp_valid = (r_state == S_RESP);
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_accept     = 1'b1;
          w_state_next = (bus.req_op == OP_CLEAR) ? S_CLEAR : S_PROBE;
        end
      end
      S_PROBE: begin
        case (r_op)
          OP_LOOKUP: begin
            if (w_match) begin
              w_finish = 1'b1;
              w_hit_n  = 1'b1;
              w_data_n = r_mem_data[w_addr];
            end else if (w_last) begin
              w_finish = 1'b1;
            end
          end
          OP_INSERT: begin
            if (w_match) begin
              w_finish = 1'b1;
              w_hit_n  = 1'b1;
              w_wr_en  = 1'b1;
            end else if (w_last) begin
              w_finish = 1'b1;
              // The last way itself may be the first free slot seen.
              if (r_free_found || !r_valid[w_addr]) begin
                w_wr_en     = 1'b1;
                w_set_valid = 1'b1;
                w_inc       = 1'b1;
                w_wr_addr   = r_free_found ? w_free_addr : w_addr;
              end else begin
                w_full_n = 1'b1;
              end
            end
          end
          default: begin
            if (w_match) begin
              w_finish    = 1'b1;
              w_hit_n     = 1'b1;
              w_clr_valid = 1'b1;
              w_dec       = 1'b1;
            end else if (w_last) begin
              w_finish = 1'b1;
            end
          end
        endcase
        if (w_finish) w_state_next = S_RESP;
      end
      S_CLEAR: begin
        // One bucket per cycle, then one extra cycle to publish the response.
        if (r_clr_idx == (IDX_W+1)'(BUCKETS)) begin
          w_finish     = 1'b1;
          w_clr_cnt    = 1'b1;
          w_state_next = S_RESP;
        end else begin
          w_clr_bucket = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Per-entry valid update: set by insert, cleared by delete or bucket clear.
  logic [ENTRIES-1:0] w_valid_next;
  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      localparam int BKT = gi / WAYS;
      logic w_set, w_clr;
      assign w_set = w_set_valid && (w_wr_addr == ADDR_W'(gi));
      assign w_clr = (w_clr_valid && (w_addr == ADDR_W'(gi))) ||
                     (w_clr_bucket && (r_clr_idx == (IDX_W+1)'(BKT)));
      assign w_valid_next[gi] = w_set | (r_valid[gi] & ~w_clr);
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_valid <= '0;
    else       r_valid <= w_valid_next;
  end

  // Key/data storage needs no reset: stale contents are masked by valid.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem_key[w_wr_addr]  <= r_key;
      r_mem_data[w_wr_addr] <= r_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op         <= '0;
      r_key        <= '0;
      r_data       <= '0;
      r_bucket     <= '0;
      r_way        <= '0;
      r_free_found <= 1'b0;
      r_free_way   <= '0;
      r_clr_idx    <= '0;
      r_count      <= '0;
      r_rsp_hit    <= 1'b0;
      r_rsp_full   <= 1'b0;
      r_rsp_data   <= '0;
    end else begin
      if (w_accept) begin
        r_op         <= bus.req_op;
        r_key        <= bus.req_key;
        r_data       <= bus.req_data;
        r_bucket     <= w_hash;
        r_way        <= '0;
        r_free_found <= 1'b0;
        r_free_way   <= '0;
        r_clr_idx    <= '0;
      end
      if (r_state == S_PROBE && !w_finish) begin
        r_way <= r_way + WAY_W'(1);
        if (!r_free_found && !r_valid[w_addr]) begin
          r_free_found <= 1'b1;
          r_free_way   <= r_way;
        end
      end
      if (w_clr_bucket) r_clr_idx <= r_clr_idx + (IDX_W+1)'(1);
      if (w_finish) begin
        r_rsp_hit  <= w_hit_n;
        r_rsp_full <= w_full_n;
        r_rsp_data <= w_data_n;
      end
      if (w_clr_cnt)  r_count <= '0;
      else if (w_inc) r_count <= r_count + CNT_W'(1);
      else if (w_dec) r_count <= r_count - CNT_W'(1);
    end
  end

  assign bus.rsp_hit     = r_rsp_hit;
  assign bus.rsp_full    = r_rsp_full;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.entry_count = r_count;
endmodule

// File: tb/tb_hash_dictionary_engine.sv
module tb_hash_dictionary_engine;
  localparam int KEY_W   = 8;
  localparam int DATA_W  = 8;
  localparam int BUCKETS = 16;
  localparam int WAYS    = 4;
  localparam int IDX_W   = $clog2(BUCKETS);
  localparam int CNT_W   = $clog2(BUCKETS*WAYS+1);
  localparam int TIMEOUT = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hash_dictionary_engine_if #(.KEY_W(KEY_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  hash_dictionary_engine #(.KEY_W(KEY_W), .DATA_W(DATA_W), .BUCKETS(BUCKETS), .WAYS(WAYS)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic              hit;
    logic              full;
    logic [DATA_W-1:0] data;
    int                lat;
    int                cnt;
    int                acc;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int vis_count = 0;
  exp_t q[$];

  // Reference table: plain 2-D arrays indexed by bucket and way.
  logic              m_valid [BUCKETS][WAYS];
  logic [KEY_W-1:0]  m_key   [BUCKETS][WAYS];
  logic [DATA_W-1:0] m_data  [BUCKETS][WAYS];
  int                m_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic timeout_fail(input string what);
    checks++;
    errors++;
    $display("FAIL timeout %s: no progress within %0d cycles", what, TIMEOUT);
    finish_sim();
  endtask

  function automatic int hash_of(input logic [KEY_W-1:0] k);
    int h = 0;
    for (int i = 0; i < KEY_W; i += IDX_W) h = h ^ ((int'(k) >> i) & (BUCKETS - 1));
    return h;
  endfunction

  task automatic model_clear();
    for (int b = 0; b < BUCKETS; b++)
      for (int w = 0; w < WAYS; w++) m_valid[b][w] = 1'b0;
    m_count = 0;
  endtask

  // Decide the outcome of one operation from the dictionary rules and update the table.
  task automatic model_apply(input logic [1:0] op, input logic [KEY_W-1:0] key,
                             input logic [DATA_W-1:0] data, output exp_t e);
    int b, mw, fw;
    b = hash_of(key);
    mw = -1;
    fw = -1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (m_valid[b][w] && m_key[b][w] == key) mw = w;
      if (!m_valid[b][w]) fw = w;
    end
    e.hit = 1'b0; e.full = 1'b0; e.data = '0; e.lat = WAYS; e.acc = 0;
    case (op)
      2'b00: if (mw >= 0) begin e.hit = 1'b1; e.data = m_data[b][mw]; e.lat = mw + 1; end
      2'b01: begin
        if (mw >= 0) begin
          m_data[b][mw] = data; e.hit = 1'b1; e.lat = mw + 1;
        end else if (fw >= 0) begin
          m_valid[b][fw] = 1'b1; m_key[b][fw] = key; m_data[b][fw] = data; m_count++;
        end else begin
          e.full = 1'b1;
        end
      end
      2'b10: if (mw >= 0) begin m_valid[b][mw] = 1'b0; m_count--; e.hit = 1'b1; e.lat = mw + 1; end
      default: begin model_clear(); e.lat = BUCKETS + 1; end
    endcase
    e.cnt = m_count;
  endtask

  // Compare process: every cycle, against the expectation queue.
  initial begin
    logic              in_rsp;
    logic              h_hit, h_full;
    logic [DATA_W-1:0] h_data;
    exp_t              e;
    in_rsp = 1'b0;
    h_hit = 1'b0; h_full = 1'b0; h_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_rsp = 1'b0;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_hit", 32'(bus.rsp_hit), 32'd0);
        chk("rst_rsp_full", 32'(bus.rsp_full), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_entry_count", 32'(bus.entry_count), 32'd0);
      end else begin
        if (bus.rsp_valid) begin
          if (!in_rsp) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_rsp: rsp_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
              e = q[0];
              chk("rsp_hit", 32'(bus.rsp_hit), 32'(e.hit));
              chk("rsp_full", 32'(bus.rsp_full), 32'(e.full));
              chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
              chk("latency", 32'(cyc - e.acc), 32'(e.lat));
              vis_count = e.cnt;
              in_rsp = 1'b1;
              h_hit = bus.rsp_hit; h_full = bus.rsp_full; h_data = bus.rsp_data;
            end
          end else begin
            chk("hold_hit", 32'(bus.rsp_hit), 32'(h_hit));
            chk("hold_full", 32'(bus.rsp_full), 32'(h_full));
            chk("hold_data", 32'(bus.rsp_data), 32'(h_data));
          end
          chk("req_ready_in_rsp", 32'(bus.req_ready), 32'd0);
          if (bus.rsp_ready && in_rsp) begin
            void'(q.pop_front());
            in_rsp = 1'b0;
            done_cnt++;
          end
        end
        chk("entry_count", 32'(bus.entry_count), 32'(vis_count));
      end
    end
  end

  // Issue one op and wait for its response handshake; hold = cycles rsp_ready stays low.
  task automatic do_op(input logic [1:0] op, input logic [KEY_W-1:0] key,
                       input logic [DATA_W-1:0] data, input int hold, output exp_t e);
    int n;
    int start_done;
    n = 0;
    while (!bus.req_ready && n < TIMEOUT) begin @(posedge clk); #1; n++; end
    if (!bus.req_ready) timeout_fail("req_ready");
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_key = key; bus.req_data = data;
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    model_apply(op, key, data, e);
    e.acc = cyc;
    q.push_back(e);
    start_done = done_cnt;
    n = 0;
    while (!bus.rsp_valid && n < TIMEOUT) begin @(posedge clk); #1; n++; end
    if (!bus.rsp_valid) timeout_fail("rsp_valid");
    repeat (hold) begin @(posedge clk); #1; end
    bus.rsp_ready = 1'b1;
    n = 0;
    while (done_cnt == start_done && n < TIMEOUT) begin @(posedge clk); #1; n++; end
    if (done_cnt == start_done) timeout_fail("rsp_handshake");
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    exp_t e;
    logic [3:0] hi;
    int r;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_key = '0; bus.req_data = '0;
    bus.rsp_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed sequence; literal checks pin the reference model.
    do_op(2'b01, 8'h12, 8'hAA, 0, e);
    chk("p_ins12_lat", 32'(e.lat), 32'd4); chk("p_ins12_hit", 32'(e.hit), 32'd0);
    chk("p_ins12_cnt", 32'(e.cnt), 32'd1);
    do_op(2'b00, 8'h12, 8'h00, 0, e);
    chk("p_lk12_lat", 32'(e.lat), 32'd1); chk("p_lk12_data", 32'(e.data), 32'hAA);
    do_op(2'b01, 8'h12, 8'hBB, 0, e);
    chk("p_upd12_hit", 32'(e.hit), 32'd1); chk("p_upd12_cnt", 32'(e.cnt), 32'd1);
    do_op(2'b00, 8'h12, 8'h00, 1, e);
    chk("p_lk12b_data", 32'(e.data), 32'hBB);
    do_op(2'b01, 8'h21, 8'h01, 0, e);
    do_op(2'b01, 8'h30, 8'h02, 0, e);
    do_op(2'b01, 8'h03, 8'h03, 0, e);
    do_op(2'b01, 8'h47, 8'h04, 0, e);
    chk("p_full47_full", 32'(e.full), 32'd1); chk("p_full47_cnt", 32'(e.cnt), 32'd4);
    do_op(2'b10, 8'h21, 8'h00, 0, e);
    chk("p_del21_lat", 32'(e.lat), 32'd2); chk("p_del21_cnt", 32'(e.cnt), 32'd3);
    do_op(2'b01, 8'h47, 8'h05, 0, e);
    chk("p_ins47_full", 32'(e.full), 32'd0);
    do_op(2'b00, 8'h47, 8'h00, 0, e);
    chk("p_lk47_lat", 32'(e.lat), 32'd2); chk("p_lk47_data", 32'(e.data), 32'h05);
    do_op(2'b01, 8'h00, 8'h55, 0, e);
    do_op(2'b00, 8'h00, 8'h00, 0, e);
    chk("p_lk00_hit", 32'(e.hit), 32'd1); chk("p_lk00_data", 32'(e.data), 32'h55);
    do_op(2'b00, 8'h44, 8'h00, 0, e);
    chk("p_lk44_hit", 32'(e.hit), 32'd0); chk("p_lk44_lat", 32'(e.lat), 32'd4);
    do_op(2'b00, 8'h30, 8'h00, 10, e);
    do_op(2'b11, 8'h00, 8'h00, 0, e);
    chk("p_clr_lat", 32'(e.lat), 32'd17); chk("p_clr_cnt", 32'(e.cnt), 32'd0);
    do_op(2'b00, 8'h12, 8'h00, 0, e);
    do_op(2'b00, 8'h47, 8'h00, 0, e);
    do_op(2'b00, 8'h00, 8'h00, 0, e);
    chk("p_postclr_hit", 32'(e.hit), 32'd0);

    // Random traffic concentrated on buckets 0 and 1 so buckets fill up.
    for (int i = 0; i < 300; i++) begin
      hi = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 99);
      do_op((r < 35) ? 2'b00 : (r < 75) ? 2'b01 : (r < 97) ? 2'b10 : 2'b11,
            {hi, hi ^ 4'($urandom_range(0, 1))}, 8'($urandom_range(0, 255)),
            $urandom_range(0, 2), e);
    end

    // Reset two cycles into an insert probe.
    do_op(2'b01, 8'h12, 8'h66, 0, e);
    do_op(2'b01, 8'h56, 8'h77, 0, e);
    bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.req_key = 8'h65; bus.req_data = 8'h11;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    model_clear();
    vis_count = 0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    do_op(2'b00, 8'h12, 8'h00, 0, e);
    do_op(2'b00, 8'h56, 8'h00, 0, e);
    do_op(2'b00, 8'h65, 8'h00, 0, e);
    chk("p_postrst_hit", 32'(e.hit), 32'd0);
    do_op(2'b01, 8'h65, 8'h22, 0, e);
    do_op(2'b00, 8'h65, 8'h00, 0, e);
    repeat (3) @(posedge clk);
    finish_sim();
  end
endmodule

// File: doc/hash_dictionary_engine.md
# hash_dictionary_engine

Parametrised, multi-cycle hash dictionary that stores key/data pairs in a bucketed, set-associative table with per-entry valid bits. It supports lookup, insert/update, delete and whole-table clear over a valid/ready request and response interface. It is the dictionary stage of the compression datapath and replaces the fixed 8-bit, 16×4 single-cycle table with a probing state machine that scales in width and depth.

## Interface
- KEY_W, 8, key width in bits.
- DATA_W, 8, data width in bits.
- BUCKETS, 16, number of buckets; power of two, ≥2; IDX_W = log2(BUCKETS).
- WAYS, 4, entries per bucket, ≥1.
- CNT_W, derived, clog2(BUCKETS*WAYS+1).

- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  engine can accept a request.
- req_op  input  2  00 lookup, 01 insert/update, 10 delete, 11 clear.
- req_key  input  KEY_W  key; sampled on acceptance.
- req_data  input  DATA_W  insert data; sampled on acceptance.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes the response.
- rsp_hit  output  1  key found (lookup/delete), or existing entry updated (insert).
- rsp_full  output  1  insert failed: bucket full, key absent.
- rsp_data  output  DATA_W  lookup data on hit; 0 otherwise.
- entry_count  output  CNT_W  number of valid entries.

## Operation
- Hash: key zero-extended to a multiple of IDX_W, split into IDX_W-bit chunks, all XORed. Default: key[3:0]^key[7:4].
- Entry = {valid, key, data}. Key 0 is a legal key; occupancy comes only from valid.
- States: IDLE, PROBE, RESP, CLEAR.
- IDLE: req_ready=1. On req_valid&&req_ready, latch op/key/data/bucket, way=0; op 11 → CLEAR, otherwise → PROBE.
- PROBE: one way per cycle. Match = valid && stored key == latched key.
  - Lookup: match → rsp_hit=1, rsp_data=stored data, → RESP; last way with no match → hit=0, data=0, → RESP.
  - Insert: match → overwrite data, rsp_hit=1, → RESP. Record lowest invalid way seen. After last way: free way exists → write key/data, set valid, entry_count+1, hit=0, full=0; none → rsp_full=1, table unchanged.
  - Delete: match → clear valid, entry_count−1, hit=1, → RESP; no match after last way → hit=0.
- CLEAR: clear valid bits of one bucket per cycle, bucket 0 up to BUCKETS−1, then → RESP with hit=0, full=0, data=0; entry_count=0.
- RESP: rsp_valid=1, outputs stable until rsp_valid&&rsp_ready, then → IDLE. req_ready=0 in every state except IDLE.
- Reset (any time, including mid-probe or mid-clear): all valid bits 0, state IDLE, in-flight op discarded with no response.

## Timing
- Reset values: req_ready=1 (IDLE), rsp_valid=0, rsp_hit=0, rsp_full=0, rsp_data=0, entry_count=0.
- Acceptance edge E0. Way k probed in cycle k after E0; the deciding probe's result registers on the next edge.
- Lookup/delete: hit at way k → rsp_valid high k+1 cycles after E0; miss → WAYS cycles.
- Insert: update at way k → k+1 cycles; new entry or full → WAYS cycles.
- Clear: BUCKETS+1 cycles.
- Earliest next acceptance: cycle after the response handshake (one idle cycle minimum). Throughput ≤1 op per latency+2.
- Table write and entry_count change on the same edge that raises rsp_valid.
- rsp_ready held low: response holds indefinitely, no new request accepted.

## Test plan
- Reset, then insert 0x12→0xAA: rsp_valid 4 cycles after accept, hit=0, full=0, entry_count=1; lookup 0x12 → hit=1, data=0xAA, latency 1.
- Insert 0x12→0xBB: hit=1, latency 1, entry_count stays 1; lookup returns 0xBB.
- Fill bucket 3 with 0x12,0x21,0x30,0x03; insert 0x47 → full=1, count 4; delete 0x21 → hit=1, latency 2, count 3; insert 0x47 → full=0; lookup 0x47 → hit at way 1, latency 2.
- Insert key 0x00→0x55 and lookup → hit=1, data=0x55; lookup absent 0x44 → hit=0, data=0, latency 4.
- Hold rsp_ready=0 for 10 cycles: rsp outputs stable, req_ready=0; then clear op → rsp after 17 cycles, entry_count=0, all lookups miss.
- Assert reset two cycles into an insert probe: no response, entry_count=0, req_ready=1 after release, prior keys miss.
